gb_irq_ctrl: RTL

Game Boy interrupt controller: the receiving end of the single-cycle `irq` pulses raised by the timer, LCD, serial and joypad blocks. It latches the requests into IF (FF0F) and masks them with IE (FFFF). It drives a pending-interrupt line plus a halt-wake line to the CPU, and resolves the fixed-priority vector at the CPU's acknowledge. It sits between the peripherals and the CPU core on the same 4 MHz `ce` enable as the peripherals.

---
 rtl/gb_irq_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/gb_irq_ctrl.sv
// Game Boy interrupt controller: latches peripheral requests into IF, masks them with IE,
// and resolves the fixed-priority vector when the CPU acknowledges.
module gb_irq_ctrl (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  logic [4:0] irq_in,
  input  logic       cpu_sel_if,
  input  logic       cpu_sel_ie,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_di,
  output logic [7:0] cpu_do,
  input  logic       cpu_ack,
  output logic       cpu_irq,
  output logic       cpu_wake,
  output logic [7:0] irq_vector,
  output logic       dbg_state
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_DISPATCH = 1'b1;

  // Handshake: cpu_ack is a single-ce pulse, accepted only in IDLE; while in
  // DISPATCH cpu_irq is held low and any further cpu_ack is ignored.

  logic [0:0] state;
  logic [4:0] if_r;
  logic [7:0] ie_r;
  logic [4:0] pend;
  logic [4:0] win_mask;
  logic [7:0] win_vec;
  logic       ack_take;
  logic [4:0] ack_mask;
  logic [4:0] if_base;
  logic [4:0] if_next;

  assign pend = if_r & ie_r[4:0];

  always_comb begin
    win_mask = 5'b00000;
    win_vec  = 8'h00;
    casez (pend)
      5'b????1: begin win_mask = 5'b00001; win_vec = 8'h40; end
      5'b???10: begin win_mask = 5'b00010; win_vec = 8'h48; end
      5'b??100: begin win_mask = 5'b00100; win_vec = 8'h50; end
      5'b?1000: begin win_mask = 5'b01000; win_vec = 8'h58; end
      5'b10000: begin win_mask = 5'b10000; win_vec = 8'h60; end
      default:  begin win_mask = 5'b00000; win_vec = 8'h00; end
    endcase
  end

  assign ack_take = cpu_ack && (state == ST_IDLE);
  assign ack_mask = ack_take ? win_mask : 5'b00000;
  assign if_base  = (cpu_sel_if && cpu_wr) ? cpu_di[4:0] : if_r;
  // New requests are OR'd last so they survive both a CPU clear and an ack.
  assign if_next  = (if_base & ~ack_mask) | irq_in;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      if_r       <= 5'h00;
      ie_r       <= 8'h00;
      irq_vector <= 8'h00;
    end else if (ce) begin
      if_r <= if_next;
      if (cpu_sel_ie && cpu_wr) ie_r <= cpu_di;
      case (state)
        ST_IDLE: begin
          if (cpu_ack) begin
            state      <= ST_DISPATCH;
            irq_vector <= win_vec;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_irq   = (state == ST_IDLE) && (pend != 5'h00);
  assign cpu_wake  = (pend != 5'h00);
  assign dbg_state = state[0];

  always_comb begin
    cpu_do = 8'hFF;
    if (cpu_sel_if)      cpu_do = {3'b111, if_r};
    else if (cpu_sel_ie) cpu_do = ie_r;
  end

endmodule
